// File: rtl/scan_unload.sv
// -----------------------------------------------------------------------------
// scan_unload
//
// Captures a WIDTH-bit parallel word on request and unloads it serially, MSB
// first, over a valid/ready handshake. A one-cycle DONE pulse follows the last
// accepted bit. The block then returns to IDLE for at least one cycle before
// it samples REQ again.
//
// Optional feature: define SCAN_UNLOAD_PARITY_EN to add an even-parity bit
// after the data bits. The bit is the XOR of the captured word. With the
// macro undefined, the PAR state and the parity register are not built.
//
// Ports
//   CK      in   clock; all state changes on its rising edge
//   RN      in   asynchronous active-low reset
//   REQ     in   capture-and-unload request, sampled only in IDLE
//   PI      in   [WIDTH-1:0] parallel word, sampled on the accepting edge
//   SO_RDY  in   downstream accepts the current serial bit
//   SO      out  serial data, MSB first
//   SO_VLD  out  SO holds a valid bit
//   BUSY    out  an unload is in progress (SHIFT or PAR)
//   DONE    out  one-cycle pulse after the last bit is accepted
// -----------------------------------------------------------------------------
module scan_unload #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             REQ,
    input  logic [WIDTH-1:0] PI,
    input  logic             SO_RDY,
    output logic             SO,
    output logic             SO_VLD,
    output logic             BUSY,
    output logic             DONE
);

    // The counter holds 0..WIDTH, so it never wraps during an unload.
    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SCAN_UNLOAD_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef SCAN_UNLOAD_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic last_bit;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a signal unassigned would otherwise infer a latch.
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef SCAN_UNLOAD_PARITY_EN
        parity_d = parity_q;
`endif
        SO       = 1'b0;
        SO_VLD   = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;

        case (state_q)
            IDLE: begin
                // Ternaries rather than if/else: an X on REQ must propagate into
                // the state and datapath. An if/else would quietly treat it as 0.
                state_d  = REQ ? SHIFT : IDLE;
                shreg_d  = REQ ? PI : shreg_q;
                cnt_d    = REQ ? '0 : cnt_q;
`ifdef SCAN_UNLOAD_PARITY_EN
                parity_d = REQ ? ^PI : parity_q;
`endif
            end

            SHIFT: begin
                SO     = shreg_q[WIDTH-1];
                SO_VLD = 1'b1;
                BUSY   = 1'b1;
                if (SO_RDY) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef SCAN_UNLOAD_PARITY_EN
                        state_d = PAR;
`else
                        state_d = FIN;
`endif
                    end
                end
            end

`ifdef SCAN_UNLOAD_PARITY_EN
            PAR: begin
                SO     = parity_q;
                SO_VLD = 1'b1;
                BUSY   = 1'b1;
                if (SO_RDY) begin
                    state_d = FIN;
                end
            end
`endif

            FIN: begin
                // REQ is ignored here. That guarantees one IDLE cycle
                // between back-to-back unloads.
                DONE    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                // Reached only from an X or unused encoding. Propagate the
                // X instead of masking it.
                state_d = state_t'(2'bxx);
                shreg_d = 'x;
                cnt_d   = 'x;
                SO      = 1'bx;
                SO_VLD  = 1'bx;
                BUSY    = 1'bx;
                DONE    = 1'bx;
            end
        endcase
    end

    // State registers. Reset forces IDLE and clears the datapath, so every
    // output decodes to 0 right away, independent of CK.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SCAN_UNLOAD_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments. Every register samples the
            // pre-edge values, whatever order these lines are in.
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SCAN_UNLOAD_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: doc/scan_unload.md
SCAN_UNLOAD -- requirements
Module: scan_unload

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of captured bits (legal range 2..32).
REQ-002 The module SHALL have port CK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The module SHALL have port RN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port REQ, input, 1 bit: capture-and-unload request.
REQ-005 The module SHALL have port PI, input, WIDTH bits: parallel word to capture.
REQ-006 The module SHALL have port SO_RDY, input, 1 bit: downstream accepts the current serial bit.
REQ-007 The module SHALL have port SO, output, 1 bit: serial data out, MSB first.
REQ-008 The module SHALL have port SO_VLD, output, 1 bit: SO holds a valid bit.
REQ-009 The module SHALL have port BUSY, output, 1 bit: an unload is in progress.
REQ-010 The module SHALL have port DONE, output, 1 bit: one-cycle pulse after the last bit is accepted.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, PAR, and FIN, and SHALL be encoded in registers clocked only by CK.
REQ-012 In IDLE with REQ=1 at a CK rising edge, the block SHALL load PI into the shift register and enter SHIFT, with BUSY=1 and SO_VLD=1 from the next cycle (1-cycle latency).
REQ-013 In SHIFT, SO SHALL equal the shift register MSB.
REQ-014 A bit SHALL be transferred only on an edge where SO_VLD=1 and SO_RDY=1.
REQ-015 On each transfer the register SHALL shift left by one with zero fill, and the bit counter SHALL increment.
REQ-016 With SO_RDY=0, SO, SO_VLD, the register and the counter SHALL all hold; there is no timeout.
REQ-017 After transfer of bit WIDTH-1, the FSM SHALL go to PAR if parity is configured, else to FIN.
REQ-018 In PAR, SO SHALL equal the stored parity bit with SO_VLD=1, and its transfer SHALL move the FSM to FIN.
REQ-019 In FIN, the outputs SHALL be DONE=1, SO_VLD=0 and BUSY=0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-020 REQ SHALL be ignored in SHIFT, PAR and FIN, and SHALL be sampled again only in IDLE, so back-to-back unloads have one idle gap minimum.
REQ-021 PI SHALL be sampled only on the accepting edge, and later PI changes SHALL NOT affect the unload.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits, SHALL never wrap during an unload, and SHALL be cleared on entry to SHIFT.
REQ-023 In IDLE, SO and SO_VLD SHALL be 0.
REQ-024 An X on REQ in IDLE SHALL drive the state and outputs to X (no optimistic masking).

Reset
REQ-025 RN=0 SHALL immediately force, independent of CK: FSM=IDLE, shift register=0, counter=0, parity=0, SO=0, SO_VLD=0, BUSY=0, DONE=0.
REQ-026 Reset asserted mid-unload SHALL abort it with no DONE pulse, and untransferred bits SHALL be lost.
REQ-027 On RN release, the first REQ SHALL be accepted on the first CK rising edge with RN=1.

Configuration
REQ-028 The macro SCAN_UNLOAD_PARITY_EN, when defined, SHALL compile in the PAR state and the parity register.
REQ-029 With SCAN_UNLOAD_PARITY_EN defined, the parity register SHALL capture the even parity (XOR of all PI bits) on the accepting edge, and each unload SHALL be WIDTH+1 bits long.
REQ-030 With SCAN_UNLOAD_PARITY_EN undefined, the PAR state and the parity register SHALL be absent, each unload SHALL be WIDTH bits long, and SHIFT SHALL go directly to FIN.

Verification
REQ-031 A directed test SHALL apply WIDTH=8, PI=8'hA5, REQ pulse, SO_RDY=1, and SHALL check that SO is 1,0,1,0,0,1,0,1 on consecutive cycles, DONE pulses once 9 cycles after the REQ edge, and BUSY=1 for 8 cycles (no parity).
REQ-032 A directed test SHALL apply the same stimulus with SCAN_UNLOAD_PARITY_EN defined and PI=8'h07, and SHALL check that the 9th bit is 1 and DONE is delayed by one cycle.
REQ-033 A directed test SHALL hold SO_RDY=0 for 5 cycles after bit 3, and SHALL check that SO/SO_VLD hold bit 3, the sequence is otherwise unchanged, and DONE is delayed by exactly 5 cycles.
REQ-034 A directed test SHALL pulse RN low during bit 4 of an unload, and SHALL check that all outputs are 0 asynchronously, no DONE occurs, and a new REQ with PI=8'h3C unloads correctly.
REQ-035 A directed test SHALL hold REQ=1 continuously, and SHALL check that unloads occur back-to-back, separated by the FIN and IDLE cycles, with PI changes mid-unload not corrupting the output.
REQ-036 A directed test SHALL set WIDTH=2 with PI=2'b10, and SHALL check the boundary sequence SO=1,0 followed by DONE.
